ql_scan_loader: RTL and testbench
=================================

# ql_scan_loader

Serial configuration-chain driver for the K4N8 fabric model: accepts bitstream words over a valid/ready stream and shifts them, one bit per clock, into a chain of `scff` scan flops, which receive the bits on their `D` input. Sits between the testbench/config controller and the `scff` chain in simulation and emulation netlists. It gates shifting with an enable, counts exactly `CHAIN_LEN` shifts, and reports completion. Optional readback captures the bits leaving the chain tail.

## Interface
- `CHAIN_LEN`, 64: number of `scff` cells in the chain (≥1).
- `WORD_W`, 8: bitstream word width (≥1).
- `clk`  in  1  chain/shift clock.
- `R`  in  1  reset, asynchronous, active-high.
- `start`  in  1  single-cycle request to begin a load; honoured only in IDLE.
- `s_data`  in  WORD_W  bitstream word; bit 0 is shifted first.
- `s_valid`  in  1  `s_data` valid.
- `s_ready`  out  1  loader accepts a word this cycle.
- `scan_out`  out  1  serial data to the `D` input of the first `scff`.
- `scan_en`  out  1  chain shifts on this `clk` edge; it gates the chain clock.
- `busy`  out  1  load in progress.
- `done`  out  1  one-cycle pulse after the last chain bit shifts.
- `scan_in`  in  1  tail `scff` Q; present only with readback.
- `rb_data`  out  WORD_W  readback word; present only with readback.
- `rb_valid`  out  1  `rb_data` valid pulse; present only with readback.

## Operation
- Words per load: NW = ceil(CHAIN_LEN/WORD_W). In the last word, only the low CHAIN_LEN − (NW−1)·WORD_W bits shift. Its unused upper bits are discarded.
- FSM states:
  - IDLE: `start` → LOAD; `busy` is set.
  - LOAD: `s_ready`=1. On `s_valid&&s_ready`, latch the word into the shift register, clear the bit index, then go to SHIFT.
  - SHIFT: `scan_en`=1 and `scan_out`=shreg[0]. Each cycle, shreg shifts right, the bit index increments and the remaining-bit counter decrements. When the word is exhausted and bits remain → LOAD. When the remaining count reaches 0 → DONE.
  - DONE: `done`=1 for one cycle and `busy` drops; the next state is IDLE.
- `scan_en` is high for exactly CHAIN_LEN cycles per load. It is never high in IDLE, LOAD or DONE, so the chain holds while the loader waits for a word.
- `s_ready` is low outside LOAD. Data offered early is not consumed.
- `start` is ignored when not in IDLE. `start` in the DONE cycle is also ignored.
- Counters:
  - remaining-bit counter: $clog2(CHAIN_LEN+1) bits.
  - bit index: $clog2(WORD_W+1) bits.
  - No wrap-around is permitted; the remaining count saturates at 0.
- Case CHAIN_LEN ≤ WORD_W: a single word, one LOAD, CHAIN_LEN SHIFT cycles.
- Reset mid-operation: all state returns to IDLE immediately. Chain contents are undefined afterwards and a full reload is required.

## Timing
- Reset values:
  - `s_ready`=0, `scan_out`=0, `scan_en`=0, `busy`=0, `done`=0.
  - `rb_data`=0, `rb_valid`=0.
  - FSM in IDLE.
- Outputs are registered or decoded from state only; there is no combinational path from `s_valid` to `s_ready`.
- `start` at edge t → LOAD (with `s_ready`) from t+1.
- Word accepted at edge a → first `scan_en` cycle at a+1.
- Each word costs 1 LOAD cycle plus its shift cycles. Minimum load time: NW + CHAIN_LEN + 1 (DONE) cycles after `start`.
- `done` is asserted in the cycle after the final `scan_en` cycle.

## Configuration
- `QL_SCAN_READBACK_EN` defined:
  - Adds the `scan_in`, `rb_data` and `rb_valid` ports.
  - `scan_in` is sampled on every `scan_en` cycle, which yields the old chain contents with the tail bit first. Samples are packed LSB-first.
  - `rb_valid` pulses for one cycle after each WORD_W samples, and after the final partial word, which is zero-padded.
  - Readback has no backpressure.
- Macro undefined: none of these ports or registers exist, and the behaviour is otherwise identical.

## Structure
- Shared package `ql_scan_pkg`:
  - FSM state enum {IDLE, LOAD, SHIFT, DONE}.
  - Width helper functions for the counters.
- One sub-module, `ql_scan_shreg`: parallel-load, serial-out shift register with an optional serial-in capture register. It is reused for readback packing.

## Test plan
- Exact fit: CHAIN_LEN=16, WORD_W=8, words 0xA5 then 0x3C → `scan_out` sequence 1,0,1,0,0,1,0,1, 0,0,1,1,1,1,0,0. `scan_en` high exactly 16 cycles. `done` pulses once.
- Partial last word: CHAIN_LEN=10, WORD_W=8, words 0xFF, 0xFE → 10 shifts, the last two bits are 0,1, and there is no 11th `scan_en`.
- Backpressure: `s_valid` dropped for 5 cycles between words → `scan_en` is low for those cycles, the chain holds, and the final chain contents match the no-stall run.
- Reset mid-shift: assert `R` after 3 shift cycles → all outputs 0 in the same cycle. A fresh `start` then produces a full CHAIN_LEN-cycle reload.
- Ignored start: pulse `start` during SHIFT and during DONE → no restart and exactly one `done`.
- Readback (`QL_SCAN_READBACK_EN`): drive a 16-cell model preloaded with 0x1234 and load 0x0000 → `rb_data` is 0x34 then 0x12, with two `rb_valid` pulses.

Source files
------------

// File: rtl/ql_scan_pkg.sv
// ql_scan_pkg: shared FSM state type and counter-width helpers for the scan loader
package ql_scan_pkg;
  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_e;
  function automatic int rem_w(input int chain_len);
    return $clog2(chain_len + 1);
  endfunction
  function automatic int idx_w(input int word_w);
    return $clog2(word_w + 1);
  endfunction
endpackage

// File: rtl/ql_scan_shreg.sv
// ql_scan_shreg: parallel-load, shift-right register; sin enters at the MSB so W shifts pack samples LSB-first
module ql_scan_shreg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ld,
  input  logic [W-1:0] ld_data,
  input  logic         sh,
  input  logic         sin,
  output logic [W-1:0] q
);
  logic [W-1:0] q_q, q_d;
  always_comb q_d = ld ? ld_data : sh ? ((q_q >> 1) | (W'(sin) << (W - 1))) : q_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) q_q <= '0;
    else q_q <= q_d;
  assign q = q_q;
endmodule

// File: rtl/ql_scan_loader.sv
// ql_scan_loader: word-stream to scff-chain serial loader; define QL_SCAN_READBACK_EN to capture the chain tail
module ql_scan_loader
  import ql_scan_pkg::*;
#(
  parameter int CHAIN_LEN = 64,
  parameter int WORD_W    = 8
) (
  input  logic              clk,
  input  logic              R,
  input  logic              start,
  input  logic [WORD_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic              scan_out,
  output logic              scan_en,
  output logic              busy,
  output logic              done
`ifdef QL_SCAN_READBACK_EN
  ,
  input  logic              scan_in,
  output logic [WORD_W-1:0] rb_data,
  output logic              rb_valid
`endif
);
  localparam int RW = rem_w(CHAIN_LEN);
  localparam int IW = idx_w(WORD_W);
  state_e state_q, state_d;
  logic [RW-1:0] rem_q, rem_d;
  logic [IW-1:0] idx_q, idx_d, nb_q, nb_d;
  logic [WORD_W-1:0] sr_q;
  logic accept, word_end, last_bit;
  assign accept   = state_q == LOAD && s_valid;
  assign word_end = idx_q + IW'(1) == nb_q;
  assign last_bit = rem_q == RW'(1);
  // nb holds how many bits of the current word really shift; only the last word can be short
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    idx_d   = idx_q;
    nb_d    = nb_q;
    case (state_q)
      IDLE: if (start) begin
        state_d = LOAD;
        rem_d   = RW'(CHAIN_LEN);
      end
      LOAD: if (s_valid) begin
        state_d = SHIFT;
        idx_d   = '0;
        nb_d    = (int'(rem_q) < WORD_W) ? IW'(rem_q) : IW'(WORD_W);
      end
      SHIFT: begin
        idx_d   = idx_q + IW'(1);
        rem_d   = (rem_q == '0) ? '0 : rem_q - RW'(1);
        state_d = (last_bit || rem_q == '0) ? DONE : word_end ? LOAD : SHIFT;
      end
      DONE: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge R)
    if (R) begin
      state_q <= IDLE;
      rem_q   <= '0;
      idx_q   <= '0;
      nb_q    <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      idx_q   <= idx_d;
      nb_q    <= nb_d;
    end
  ql_scan_shreg #(.W(WORD_W)) u_data (
    .clk(clk), .rst(R), .ld(accept), .ld_data(s_data), .sh(scan_en), .sin(1'b0), .q(sr_q)
  );
  assign s_ready  = state_q == LOAD;
  assign scan_en  = state_q == SHIFT;
  assign scan_out = scan_en & sr_q[0];
  assign busy     = s_ready | scan_en;
  assign done     = state_q == DONE;
`ifdef QL_SCAN_READBACK_EN
  // a short final word sits in the top bits of the capture register; shifting down right-aligns and zero-pads it
  logic [WORD_W-1:0] cap_q;
  logic rb_valid_q, rb_valid_d;
  logic [IW-1:0] rb_sh_q, rb_sh_d;
  ql_scan_shreg #(.W(WORD_W)) u_cap (
    .clk(clk), .rst(R), .ld(1'b0), .ld_data('0), .sh(scan_en), .sin(scan_in), .q(cap_q)
  );
  always_comb begin
    rb_valid_d = scan_en && (word_end || last_bit);
    rb_sh_d    = IW'(WORD_W) - nb_q;
  end
  always_ff @(posedge clk or posedge R)
    if (R) begin
      rb_valid_q <= 1'b0;
      rb_sh_q    <= '0;
    end else begin
      rb_valid_q <= rb_valid_d;
      rb_sh_q    <= rb_sh_d;
    end
  assign rb_valid = rb_valid_q;
  assign rb_data  = rb_valid_q ? cap_q >> rb_sh_q : '0;
`endif
endmodule

// File: tb/tb_ql_scan_loader.sv
// tb_ql_scan_loader: randomized scoreboard bench with an scff chain model; readback checks under QL_SCAN_READBACK_EN
module tb_ql_scan_loader;
  localparam int CL = 20;
  localparam int WW = 8;
  localparam int NW = (CL + WW - 1) / WW;
  logic clk = 0, R = 1, start = 0, s_valid = 0;
  logic [WW-1:0] s_data = '0;
  logic s_ready, scan_out, scan_en, busy, done;
  logic [CL-1:0] chain = '0;
  int checks = 0, failures = 0, cyc = 0, en_cnt = 0, done_cnt = 0, loads = 0;
  bit mon_off = 1;
  bit exp_bits[$];
`ifdef QL_SCAN_READBACK_EN
  logic scan_in;
  logic [WW-1:0] rb_data;
  logic rb_valid;
  logic [WW-1:0] exp_rb[$];
  assign scan_in = chain[0];
`endif

  ql_scan_loader #(.CHAIN_LEN(CL), .WORD_W(WW)) dut (
    .clk(clk), .R(R), .start(start), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .scan_out(scan_out), .scan_en(scan_en), .busy(busy), .done(done)
`ifdef QL_SCAN_READBACK_EN
    , .scan_in(scan_in), .rb_data(rb_data), .rb_valid(rb_valid)
`endif
  );

  always #5 clk = ~clk;

  // scff chain: head receives scan_out, chain[0] is the tail
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (scan_en) chain <= {scan_out, chain[CL-1:1]};
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) if (!mon_off) begin
    if (scan_en) begin
      en_cnt++;
      if (exp_bits.size() == 0) check("extra_scan_en", scan_en, 0);
      else check("scan_out", scan_out, exp_bits.pop_front());
    end
    if (done) done_cnt++;
    check("ready_en_exclusive", s_ready & scan_en, 0);
`ifdef QL_SCAN_READBACK_EN
    if (rb_valid) begin
      if (exp_rb.size() == 0) check("extra_rb_valid", rb_valid, 0);
      else check("rb_data", rb_data, exp_rb.pop_front());
    end
`endif
  end

  task automatic run_load(input int maxgap, input bit pulses, input bit lat_chk);
    logic [WW-1:0] w[NW];
    logic [CL-1:0] exp_chain;
    int sc, gap;
    bit hs, seen;
    exp_chain = '0;
    for (int i = 0; i < NW; i++) w[i] = WW'($urandom);
    for (int b = 0; b < CL; b++) begin
      exp_bits.push_back(w[b/WW][b%WW]);
      exp_chain[b] = w[b/WW][b%WW];
    end
`ifdef QL_SCAN_READBACK_EN
    for (int i = 0; i < NW; i++) exp_rb.push_back(WW'(chain >> (i * WW)));
`endif
    en_cnt = 0;
    s_data = w[0];
    s_valid = 1;
    repeat (2) begin
      @(negedge clk);
      check("idle_s_ready", s_ready, 0);
      check("idle_busy", busy, 0);
    end
    start = 1;
    @(posedge clk);
    #1 start = 0;
    sc = cyc;
    for (int i = 0; i < NW; i++) begin
      gap = (i == 0) ? 0 : $urandom_range(0, maxgap);
      if (gap > 0) begin
        s_valid = 0;
        repeat (gap) @(posedge clk);
        #1;
      end
      s_data = w[i];
      s_valid = 1;
      hs = 0;
      for (int k = 0; k < 100 && !hs; k++) begin
        @(negedge clk);
        hs = s_ready;
      end
      check("handshake", hs, 1);
      @(posedge clk);
      #1 s_valid = 0;
      s_data = WW'($urandom);
      if (pulses && i == 0) begin
        start = 1;
        @(posedge clk);
        #1 start = 0;
      end
    end
    seen = 0;
    for (int k = 0; k < 200 && !seen; k++) begin
      @(negedge clk);
      seen = done;
    end
    check("done_seen", seen, 1);
    check("scan_en_count", en_cnt, CL);
    check("chain", chain, exp_chain);
    check("queue_drained", exp_bits.size(), 0);
    if (lat_chk) check("latency", cyc - sc, NW + CL);
    if (pulses) start = 1;
    @(posedge clk);
    #1 start = 0;
    loads++;
    @(negedge clk);
    check("done_pulse_once", done_cnt, loads);
    check("idle_after_done", {busy, s_ready, done}, 0);
`ifdef QL_SCAN_READBACK_EN
    check("rb_drained", exp_rb.size(), 0);
`endif
  endtask

  task automatic reset_mid_shift();
    bit hs;
    mon_off = 1;
    s_data = WW'($urandom);
    s_valid = 1;
    start = 1;
    @(posedge clk);
    #1 start = 0;
    hs = 0;
    for (int k = 0; k < 100 && !hs; k++) begin
      @(negedge clk);
      hs = s_ready;
    end
    check("rst_handshake", hs, 1);
    @(posedge clk);
    #1 s_valid = 0;
    repeat (3) @(posedge clk);
    #2 check("pre_rst_scan_en", scan_en, 1);
    R = 1;
    #1;
    check("rst_outs", {s_ready, scan_out, scan_en, busy, done}, 0);
`ifdef QL_SCAN_READBACK_EN
    check("rst_rb", {rb_valid, rb_data}, 0);
`endif
    @(negedge clk);
    R = 0;
    exp_bits.delete();
`ifdef QL_SCAN_READBACK_EN
    exp_rb.delete();
`endif
    mon_off = 0;
  endtask

  initial begin
    #2;
    check("reset_outs", {s_ready, scan_out, scan_en, busy, done}, 0);
`ifdef QL_SCAN_READBACK_EN
    check("reset_rb", {rb_valid, rb_data}, 0);
`endif
    @(negedge clk);
    R = 0;
    mon_off = 0;
    run_load(0, 0, 1);
    for (int n = 0; n < 6; n++) run_load(14, 1'($urandom_range(0, 1)), 0);
    run_load(0, 1, 0);
    reset_mid_shift();
    run_load(6, 0, 0);
    run_load(0, 0, 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end
endmodule
